yarvi_irq_ctrl: RTL

YARVI_IRQ_CTRL -- requirements
Module: yarvi_irq_ctrl

---
 rtl/yarvi_irq_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/yarvi_irq_ctrl.sv
// Machine-mode interrupt controller: mstatus/mie/mip/mcause CSRs, a prescaled
// mtime/mtimecmp timer and prioritised external lines feeding one request to the core.
module yarvi_irq_ctrl #(
    parameter int              NSRC      = 4,
    parameter logic [NSRC-1:0] EDGE_MASK = '0,
    parameter int              TIME_W    = 64,
    parameter int              PRESCALE  = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [11:0]     csr_no,
    input  logic            csr_we,
    input  logic            csr_re,
    input  logic [31:0]     csr_wdata,
    output logic [31:0]     csr_rdata,
    output logic            csr_rdata_valid,
    input  logic [NSRC-1:0] irq_src,
    output logic            irq_req,
    output logic [4:0]      irq_cause,
    input  logic            irq_ack,
    input  logic            mret
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MTIME_LO  = 12'h7C0;
    localparam logic [11:0] A_MTIME_HI  = 12'h7C1;
    localparam logic [11:0] A_MTCMP_LO  = 12'h7C2;
    localparam logic [11:0] A_MTCMP_HI  = 12'h7C3;

    localparam logic [31:0] EXT_MASK   = ((32'h1 << NSRC) - 32'h1) << 16;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0088 | EXT_MASK;
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic              mstatus_mie_q, mstatus_mie_d;
    logic              mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0]       mie_q, mie_d;
    logic              msip_q, msip_d;
    logic              mtip_q, mtip_d;
    logic [NSRC-1:0]   ext_pend_q, ext_pend_d;
    logic [NSRC-1:0]   src_prev_q, src_prev_d;
    logic [31:0]       mcause_q, mcause_d;
    logic [TIME_W-1:0] mtime_q, mtime_d;
    logic [TIME_W-1:0] mtimecmp_q, mtimecmp_d;
    logic [15:0]       presc_q, presc_d;
    logic              irq_req_q, irq_req_d;
    logic [4:0]        irq_cause_q, irq_cause_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;

    logic [31:0] mip_val;
    logic [31:0] pend;
    logic [31:0] rd_val;
    logic [63:0] mtime64;
    logic [63:0] mtimecmp64;
    logic        ack_take;
    logic        wr_mstatus, wr_mie, wr_mip, wr_mcause;
    logic        wr_mtime_lo, wr_mtime_hi, wr_mtcmp_lo, wr_mtcmp_hi;

    always_comb begin
        wr_mstatus  = csr_we && (csr_no == A_MSTATUS);
        wr_mie      = csr_we && (csr_no == A_MIE);
        wr_mip      = csr_we && (csr_no == A_MIP);
        wr_mcause   = csr_we && (csr_no == A_MCAUSE);
        wr_mtime_lo = csr_we && (csr_no == A_MTIME_LO);
        wr_mtime_hi = csr_we && (csr_no == A_MTIME_HI);
        wr_mtcmp_lo = csr_we && (csr_no == A_MTCMP_LO);
        wr_mtcmp_hi = csr_we && (csr_no == A_MTCMP_HI);
        ack_take    = irq_ack && irq_req_q;
        mtime64     = 64'(mtime_q);
        mtimecmp64  = 64'(mtimecmp_q);
    end

    always_comb begin
        mip_val              = '0;
        mip_val[3]           = msip_q;
        mip_val[7]           = mtip_q;
        mip_val[16 +: NSRC]  = ext_pend_q;
        pend                 = mie_q & mip_val;
    end

    // Read mux sees pre-write state, so a same-cycle write never leaks into the read.
    always_comb begin
        rd_val = '0;
        case (csr_no)
            A_MSTATUS:  rd_val = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
            A_MIE:      rd_val = mie_q;
            A_MIP:      rd_val = mip_val;
            A_MCAUSE:   rd_val = mcause_q;
            A_MTIME_LO: rd_val = mtime64[31:0];
            A_MTIME_HI: rd_val = mtime64[63:32];
            A_MTCMP_LO: rd_val = mtimecmp64[31:0];
            A_MTCMP_HI: rd_val = mtimecmp64[63:32];
            default:    rd_val = '0;
        endcase
        rdata_d       = csr_re ? rd_val : rdata_q;
        rdata_valid_d = csr_re;
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        if (ack_take) begin
            mstatus_mie_d  = 1'b0;
            mstatus_mpie_d = mstatus_mie_q;
        end else if (mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_mstatus) begin
            mstatus_mie_d  = csr_wdata[3];
            mstatus_mpie_d = csr_wdata[7];
        end

        mcause_d = mcause_q;
        if (ack_take) begin
            mcause_d = {1'b1, 26'b0, irq_cause_q};
        end else if (wr_mcause) begin
            mcause_d = csr_wdata;
        end

        mie_d  = wr_mie ? (csr_wdata & MIE_MASK) : mie_q;
        msip_d = wr_mip ? csr_wdata[3] : msip_q;
    end

    // Edge lines latch on a rising sample; a fresh edge beats a same-cycle software clear.
    always_comb begin
        src_prev_d = irq_src;
        ext_pend_d = ext_pend_q;
        for (int i = 0; i < NSRC; i++) begin
            if (EDGE_MASK[i]) begin
                ext_pend_d[i] = (irq_src[i] && !src_prev_q[i]) ||
                                (ext_pend_q[i] && !(wr_mip && !csr_wdata[16 + i]));
            end else begin
                ext_pend_d[i] = irq_src[i];
            end
        end
    end

    always_comb begin
        mtime_d    = mtime_q;
        presc_d    = presc_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_mtime_lo || wr_mtime_hi) begin
            presc_d = '0;
            if (wr_mtime_lo) mtime_d[31:0]        = csr_wdata;
            if (wr_mtime_hi) mtime_d[TIME_W-1:32] = csr_wdata[TIME_W-33:0];
        end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            mtime_d = mtime_q + TIME_W'(1);
        end else begin
            presc_d = presc_q + 16'd1;
        end
        if (wr_mtcmp_lo) mtimecmp_d[31:0]        = csr_wdata;
        if (wr_mtcmp_hi) mtimecmp_d[TIME_W-1:32] = csr_wdata[TIME_W-33:0];
        mtip_d = (mtime_q >= mtimecmp_q);
    end

    // Highest priority is evaluated last so it overrides lower-priority winners.
    always_comb begin
        irq_cause_d = 5'd0;
        if (pend[7]) irq_cause_d = 5'd7;
        if (pend[3]) irq_cause_d = 5'd3;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[16 + i]) irq_cause_d = 5'(16 + i);
        end
        irq_req_d = (|pend) && mstatus_mie_q && !irq_ack;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            msip_q         <= 1'b0;
            mtip_q         <= 1'b0;
            ext_pend_q     <= '0;
            src_prev_q     <= '0;
            mcause_q       <= '0;
            mtime_q        <= '0;
            mtimecmp_q     <= '1;
            presc_q        <= '0;
            irq_req_q      <= 1'b0;
            irq_cause_q    <= '0;
            rdata_q        <= '0;
            rdata_valid_q  <= 1'b0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            msip_q         <= msip_d;
            mtip_q         <= mtip_d;
            ext_pend_q     <= ext_pend_d;
            src_prev_q     <= src_prev_d;
            mcause_q       <= mcause_d;
            mtime_q        <= mtime_d;
            mtimecmp_q     <= mtimecmp_d;
            presc_q        <= presc_d;
            irq_req_q      <= irq_req_d;
            irq_cause_q    <= irq_cause_d;
            rdata_q        <= rdata_d;
            rdata_valid_q  <= rdata_valid_d;
        end
    end

    assign csr_rdata       = rdata_q;
    assign csr_rdata_valid = rdata_valid_q;
    assign irq_req         = irq_req_q;
    assign irq_cause       = irq_cause_q;

endmodule
